// File: rtl/clock_rst_seq.sv
// Reset sequencer for MMCM clock generators: pulses the MMCM reset, waits for a
// qualified lock (with timeout/retry) and only then releases the system reset.
module clock_rst_seq #(
   parameter int unsigned RST_CYCLES    = 8,
   parameter int unsigned LOCK_TIMEOUT  = 100000,
   parameter int unsigned STABLE_CYCLES = 16,
   parameter int unsigned CNT_W         = 20,
   parameter int unsigned RETRY_W       = 4
) (
   input  logic               clk_100m,
   input  logic               rst_n,
   input  logic               clk_locked,
   output logic               mmcm_rst,
   output logic               sys_rst,
   output logic               ready,
   output logic [RETRY_W-1:0] retries,
   output logic               lock_lost
);

   localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

   typedef enum logic [1:0] {
      RESET_MMCM = 2'd0,
      WAIT_LOCK  = 2'd1,
      STABLE     = 2'd2,
      RUN        = 2'd3
   } state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_lock_meta;
   logic               r_lock_s;

   state_t             w_next;
   logic               w_timeout;
   logic               w_lost;

   // Next-state decode; lock takes priority over the timeout in WAIT_LOCK
   always_comb begin
      w_next    = r_state;
      w_timeout = 1'b0;
      w_lost    = 1'b0;
      case (r_state)
         RESET_MMCM: begin
            if (r_cnt == RST_LAST) w_next = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (r_lock_s) begin
               w_next = STABLE;
            end else if (r_cnt == TIMEOUT_LAST) begin
               w_next    = RESET_MMCM;
               w_timeout = 1'b1;
            end
         end
         STABLE: begin
            if (!r_lock_s)                w_next = WAIT_LOCK;
            else if (r_cnt == STABLE_LAST) w_next = RUN;
         end
         RUN: begin
            if (!r_lock_s) begin
               w_next = RESET_MMCM;
               w_lost = 1'b1;
            end
         end
         default: w_next = RESET_MMCM;
      endcase
   end

   // State, counter, synchroniser and outputs decoded from the next state
   always_ff @(posedge clk_100m or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= RESET_MMCM;
         r_cnt       <= '0;
         r_lock_meta <= 1'b0;
         r_lock_s    <= 1'b0;
         mmcm_rst    <= 1'b1;
         sys_rst     <= 1'b1;
         ready       <= 1'b0;
         retries     <= '0;
         lock_lost   <= 1'b0;
      end else begin
         r_lock_meta <= clk_locked;
         r_lock_s    <= r_lock_meta;
         r_state     <= w_next;
         if (w_next != r_state) r_cnt <= '0;
         else                   r_cnt <= r_cnt + CNT_W'(1);
         mmcm_rst <= (w_next == RESET_MMCM);
         sys_rst  <= (w_next != RUN);
         ready    <= (w_next == RUN);
         if (w_timeout && (retries != '1)) retries <= retries + RETRY_W'(1);
         if (w_lost) lock_lost <= 1'b1;
      end
   end

endmodule

// File: tb/tb_clock_rst_seq.sv
// Directed bench for clock_rst_seq with short timing parameters (4/20/5).
module tb_clock_rst_seq;

   logic       clk_100m;
   logic       rst_n;
   logic       clk_locked;
   logic       mmcm_rst;
   logic       sys_rst;
   logic       ready;
   logic [3:0] retries;
   logic       lock_lost;

   int n_cmp;
   int n_fail;

   clock_rst_seq #(
      .RST_CYCLES    (4),
      .LOCK_TIMEOUT  (20),
      .STABLE_CYCLES (5),
      .CNT_W         (20),
      .RETRY_W       (4)
   ) dut (
      .clk_100m   (clk_100m),
      .rst_n      (rst_n),
      .clk_locked (clk_locked),
      .mmcm_rst   (mmcm_rst),
      .sys_rst    (sys_rst),
      .ready      (ready),
      .retries    (retries),
      .lock_lost  (lock_lost)
   );

   initial clk_100m = 1'b0;
   always #5 clk_100m = ~clk_100m;

   // Counts rising edges until the selected output (0: mmcm_rst, 1: sys_rst)
   // reaches val; returns -1 if the bound expires.
   task automatic wait_for(input int sel, input logic val, output int n);
      logic s;
      n = -1;
      for (int i = 1; i <= 64; i++) begin
         @(posedge clk_100m);
         #1;
         s = (sel == 0) ? mmcm_rst : sys_rst;
         if (s === val) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic apply_reset(input logic lock_val);
      @(posedge clk_100m);
      #1;
      rst_n      = 1'b0;
      clk_locked = lock_val;
      repeat (2) @(posedge clk_100m);
      @(negedge clk_100m);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      clk_locked = 1'b0;
      repeat (3) @(posedge clk_100m);
      #1;
      n_cmp++;
      if ({mmcm_rst, sys_rst, ready, retries, lock_lost} !== {1'b1, 1'b1, 1'b0, 4'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_values: got mmcm=%b sys=%b rdy=%b retries=%0d lost=%b, want 1 1 0 0 0",
                  mmcm_rst, sys_rst, ready, retries, lock_lost);
      end
   endtask

   task automatic test_nominal();
      int n;
      @(negedge clk_100m);
      rst_n = 1'b1;
      wait_for(0, 1'b0, n);
      n_cmp++;
      if (n !== 4) begin n_fail++; $display("FAIL nominal_mmcm_width: got %0d want 4", n); end
      repeat (10) @(posedge clk_100m);
      #1;
      clk_locked = 1'b1;
      wait_for(1, 1'b0, n);
      n_cmp++;
      if (n !== 8) begin n_fail++; $display("FAIL nominal_release: got %0d want 8", n); end
      n_cmp++;
      if ({ready, mmcm_rst, retries, lock_lost} !== {1'b1, 1'b0, 4'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL nominal_run_outputs: got rdy=%b mmcm=%b retries=%0d lost=%b, want 1 0 0 0",
                  ready, mmcm_rst, retries, lock_lost);
      end
   endtask

   task automatic test_glitch();
      int n;
      apply_reset(1'b1);
      wait_for(0, 1'b0, n);
      n_cmp++;
      if (n !== 4) begin n_fail++; $display("FAIL glitch_mmcm_width: got %0d want 4", n); end
      // STABLE entered on edge 5; glitch the lock input after edge 7 for one cycle
      repeat (3) @(posedge clk_100m);
      #1;
      clk_locked = 1'b0;
      @(posedge clk_100m);
      #1;
      clk_locked = 1'b1;
      n_cmp++;
      if (sys_rst !== 1'b1) begin n_fail++; $display("FAIL glitch_sys_rst_held: got %b want 1", sys_rst); end
      wait_for(1, 1'b0, n);
      n_cmp++;
      if (n !== 8) begin n_fail++; $display("FAIL glitch_requalify: got %0d want 8", n); end
      n_cmp++;
      if ({mmcm_rst, ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL glitch_run_outputs: got mmcm=%b rdy=%b want 0 1", mmcm_rst, ready);
      end
   endtask

   task automatic test_loss_in_run();
      int n;
      repeat (2) @(posedge clk_100m);
      #1;
      clk_locked = 1'b0;
      wait_for(1, 1'b1, n);
      n_cmp++;
      if (n !== 3) begin n_fail++; $display("FAIL loss_latency: got %0d want 3", n); end
      n_cmp++;
      if ({ready, mmcm_rst, lock_lost} !== 3'b011) begin
         n_fail++;
         $display("FAIL loss_outputs: got rdy=%b mmcm=%b lost=%b want 0 1 1", ready, mmcm_rst, lock_lost);
      end
      clk_locked = 1'b1;
      wait_for(0, 1'b0, n);
      n_cmp++;
      if (n !== 4) begin n_fail++; $display("FAIL loss_mmcm_width: got %0d want 4", n); end
      wait_for(1, 1'b0, n);
      n_cmp++;
      if (n !== 6) begin n_fail++; $display("FAIL loss_relock: got %0d want 6", n); end
      n_cmp++;
      if ({ready, lock_lost, retries} !== {1'b1, 1'b1, 4'd0}) begin
         n_fail++;
         $display("FAIL loss_sticky: got rdy=%b lost=%b retries=%0d want 1 1 0", ready, lock_lost, retries);
      end
   endtask

   task automatic test_async_mid_stable();
      int n;
      @(posedge clk_100m);
      #1;
      clk_locked = 1'b0;
      wait_for(0, 1'b1, n);
      n_cmp++;
      if (n !== 3) begin n_fail++; $display("FAIL async_loss_latency: got %0d want 3", n); end
      wait_for(0, 1'b0, n);
      wait_for(0, 1'b1, n);
      n_cmp++;
      if (n !== 20) begin n_fail++; $display("FAIL async_timeout: got %0d want 20", n); end
      wait_for(0, 1'b0, n);
      clk_locked = 1'b1;
      repeat (4) @(posedge clk_100m);
      #2;
      n_cmp++;
      if ({sys_rst, lock_lost, retries} !== {1'b1, 1'b1, 4'd1}) begin
         n_fail++;
         $display("FAIL async_precondition: got sys=%b lost=%b retries=%0d want 1 1 1", sys_rst, lock_lost, retries);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({mmcm_rst, sys_rst, ready, retries, lock_lost} !== {1'b1, 1'b1, 1'b0, 4'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL async_reset_values: got mmcm=%b sys=%b rdy=%b retries=%0d lost=%b, want 1 1 0 0 0",
                  mmcm_rst, sys_rst, ready, retries, lock_lost);
      end
      #1;
      rst_n = 1'b1;
      wait_for(0, 1'b0, n);
      n_cmp++;
      if (n !== 4) begin n_fail++; $display("FAIL async_restart_mmcm: got %0d want 4", n); end
      wait_for(1, 1'b0, n);
      n_cmp++;
      if (n !== 6) begin n_fail++; $display("FAIL async_restart_release: got %0d want 6", n); end
      n_cmp++;
      if ({ready, retries, lock_lost} !== {1'b1, 4'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL async_restart_outputs: got rdy=%b retries=%0d lost=%b want 1 0 0", ready, retries, lock_lost);
      end
   endtask

   task automatic test_timeout();
      int n;
      int exp_r;
      apply_reset(1'b0);
      wait_for(0, 1'b0, n);
      n_cmp++;
      if (n !== 4) begin n_fail++; $display("FAIL timeout_first_pulse: got %0d want 4", n); end
      for (int k = 1; k <= 16; k++) begin
         exp_r = (k > 15) ? 15 : k;
         wait_for(0, 1'b1, n);
         n_cmp++;
         if (n !== 20) begin n_fail++; $display("FAIL timeout_wait_%0d: got %0d want 20", k, n); end
         n_cmp++;
         if ({retries, sys_rst} !== {4'(exp_r), 1'b1}) begin
            n_fail++;
            $display("FAIL timeout_retries_%0d: got retries=%0d sys=%b want %0d 1", k, retries, sys_rst, exp_r);
         end
         wait_for(0, 1'b0, n);
         n_cmp++;
         if (n !== 4) begin n_fail++; $display("FAIL timeout_pulse_%0d: got %0d want 4", k, n); end
      end
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      test_reset();
      test_nominal();
      test_glitch();
      test_loss_in_run();
      test_async_mid_stable();
      test_timeout();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/clock_rst_seq.md
Name: clock_rst_seq

Overview:
- Reset sequencer for the MMCM-based clock generators. It is the controlling end of their reset/lock interface: it drives the MMCM reset and watches the returned lock flag.
- Runs on the free-running board oscillator, not on the generated clock, so it keeps working while the MMCM is unlocked.
- Holds the MMCM in reset for a fixed time, waits for lock with a timeout and retries, and requires lock to stay stable before it releases the downstream system reset.
- Recovers automatically when lock is lost.

Parameters:
- RST_CYCLES, 8, cycles mmcm_rst is held high per reset pulse (>=1).
- LOCK_TIMEOUT, 100000, cycles to wait for lock before retrying (>=2); 1 ms at 100 MHz.
- STABLE_CYCLES, 16, consecutive synced-lock-high cycles required before release (>=1).
- CNT_W, 20, state counter width; must hold max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES).
- RETRY_W, 4, width of the retry counter.

Ports:
- clk_100m  input  1  free-running 100 MHz oscillator; all logic on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clk_locked  input  1  MMCM LOCKED; asynchronous to clk_100m.
- mmcm_rst  output  1  MMCM reset, active high.
- sys_rst  output  1  downstream system reset request, active high.
- ready  output  1  high only in state RUN.
- retries  output  RETRY_W  count of lock timeouts; saturating.
- lock_lost  output  1  sticky; set when lock drops while in RUN.

Behaviour:
- Reset values (on rst_n low, immediately): state RESET_MMCM, counter 0, mmcm_rst=1, sys_rst=1, ready=0, retries=0, lock_lost=0, both sync flops 0.
- Synchroniser: clk_locked passes through a 2-flop synchroniser to give lock_s (2-cycle latency). Only lock_s is used in the FSM.
- Counter: cleared to 0 on every state transition; otherwise increments every cycle.
- All outputs are registered and decoded from the next state, so they change on the same edge as the state.
- RESET_MMCM:
  - mmcm_rst=1, sys_rst=1, ready=0.
  - When counter==RST_CYCLES-1, go to WAIT_LOCK. mmcm_rst is therefore high for exactly RST_CYCLES cycles.
- WAIT_LOCK:
  - mmcm_rst=0, sys_rst=1.
  - If lock_s=1, go to STABLE.
  - Else if counter==LOCK_TIMEOUT-1, go to RESET_MMCM and increment retries, saturating at all-ones.
  - If lock_s=1 and the timeout fall in the same cycle, lock wins: go to STABLE, no retry.
- STABLE:
  - mmcm_rst=0, sys_rst=1.
  - If lock_s=0, go to WAIT_LOCK; the timeout restarts from 0 and retries is unchanged.
  - Else when counter==STABLE_CYCLES-1, go to RUN.
- RUN:
  - mmcm_rst=0, sys_rst=0, ready=1.
  - If lock_s=0, go to RESET_MMCM and set lock_lost.
  - sys_rst=1 and ready=0 on the same edge as the transition, i.e. 3 edges after clk_locked falls (2 sync + 1).
- Glitches: a lock_s low pulse of 1 cycle in STABLE restarts qualification. The same pulse in RUN triggers a full MMCM reset.
- Sticky/persistent state: lock_lost and retries clear only on rst_n.
- Reset mid-operation: rst_n low in any state returns everything to the reset values asynchronously. Release is synchronous in effect; the sequence restarts from RESET_MMCM at counter 0.
- Nominal release latency from rst_n deasserted with clk_locked already high: RST_CYCLES cycles in RESET_MMCM, then 1 cycle in WAIT_LOCK (lock_s already 1 from the synchroniser), then STABLE_CYCLES cycles. With defaults, sys_rst falls 8+1+16=25 edges after rst_n rises.

Test Plan (RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=5):
- Reset values: hold rst_n=0 -> mmcm_rst=1, sys_rst=1, ready=0, retries=0, lock_lost=0.
- Nominal lock: release rst_n; clk_locked rises 10 cycles after mmcm_rst falls -> mmcm_rst high exactly 4 cycles, sys_rst falls 2+1+5 edges after clk_locked rises, ready=1, retries=0.
- Timeout: clk_locked held 0 -> mmcm_rst re-pulses every 4+20 cycles; retries steps 1,2,3… and saturates at 15.
- Qualification glitch: in STABLE, drop clk_locked for 1 cycle -> return to WAIT_LOCK; full 5-cycle stable window restarts; sys_rst stays 1 throughout.
- Loss in RUN: drop clk_locked -> 3 edges later sys_rst=1, ready=0, mmcm_rst=1 for 4 cycles, lock_lost=1; relock gives ready=1 again with lock_lost still 1.
- Async reset mid-STABLE: pulse rst_n low for a fraction of a cycle -> outputs return to reset values immediately; retries and lock_lost clear; sequence restarts from RESET_MMCM.
